// File: rtl/gb_io_pkg.sv
// Shared I/O register map and serial link FSM encoding.
package gb_io_pkg;

    localparam logic [15:0] ADDR_SB    = 16'hFF01;
    localparam logic [15:0] ADDR_SC    = 16'hFF02;
    localparam int          IRQ_SERIAL = 3;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_XFER_INT,
        SER_XFER_EXT,
        SER_DONE
    } ser_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input, plus one-cycle rise/fall
// pulses taken from the synchronised value.
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    // sync_sh[0..1] form the synchroniser, sync_sh[2] holds the previous synced value
    logic [2:0] sync_sh;

    // Shift the async input through the synchroniser and history flop
    always_ff @(posedge clk) begin
        if (reset) sync_sh <= {3{RESET_VAL}};
        else       sync_sh <= {sync_sh[1:0], async_in};
    end

    assign rise = sync_sh[1] & ~sync_sh[2];
    assign fall = ~sync_sh[1] & sync_sh[2];

endmodule

// File: rtl/gb_serial_link.sv
// Game Boy link port: SB/SC registers and an 8-bit full-duplex shift engine,
// acting as link clock master (internal clock) or slave (external clock).
module gb_serial_link #(
    parameter int CLK_DIV = 512
) (
    input  logic        core_clk,
    input  logic        reset,
    input  logic [15:0] address_bus_in,
    input  logic        mem_we,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        reg_hit,
    input  logic        sclk_in,
    input  logic        sin,
    output logic        sclk_out,
    output logic        sclk_oe,
    output logic        sout,
    output logic        busy,
    output logic        serial_int_req
);

    import gb_io_pkg::*;

    localparam int              PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

    ser_state_e      state, state_nx;
    logic [7:0]      sb;
    logic            sc7, sc0;
    logic [2:0]      bit_cnt;
    logic [PH_W-1:0] phase;
    logic            sout_r;
    logic            ext_rise, ext_fall;
    logic            sb_wr, sc_wr, sc_abort;

    assign sb_wr    = mem_we && (address_bus_in == ADDR_SB);
    assign sc_wr    = mem_we && (address_bus_in == ADDR_SC);
    assign sc_abort = sc_wr && !data_in[7];

    assign reg_hit  = (address_bus_in == ADDR_SB) || (address_bus_in == ADDR_SC);
    assign data_out = (address_bus_in == ADDR_SB) ? sb :
                      (address_bus_in == ADDR_SC) ? {sc7, 6'b111111, sc0} : 8'hFF;
    assign busy     = sc7;

    sync_edge_detect #(.RESET_VAL(1'b1)) u_sclk_sync (
        .clk      (core_clk),
        .reset    (reset),
        .async_in (sclk_in),
        .rise     (ext_rise),
        .fall     (ext_fall)
    );

    // FSM state register
    always_ff @(posedge core_clk) begin
        if (reset) state <= SER_IDLE;
        else       state <= state_nx;
    end

    // Next state and link-pin outputs; completion is the 7->8 bit event, not a wrap
    always_comb begin
        state_nx       = state;
        sclk_out       = 1'b1;
        sclk_oe        = 1'b0;
        sout           = 1'b1;
        serial_int_req = 1'b0;
        case (state)
            SER_IDLE: begin
                if (sc_wr && data_in[7])
                    state_nx = data_in[0] ? SER_XFER_INT : SER_XFER_EXT;
            end
            SER_XFER_INT: begin
                sclk_oe  = 1'b1;
                sclk_out = (phase >= PH_HALF);
                sout     = sout_r;
                if (sc_abort)                                state_nx = SER_IDLE;
                else if (phase == PH_LAST && bit_cnt == 3'd7) state_nx = SER_DONE;
            end
            SER_XFER_EXT: begin
                sout = sout_r;
                if (sc_abort)                         state_nx = SER_IDLE;
                else if (ext_rise && bit_cnt == 3'd7) state_nx = SER_DONE;
            end
            SER_DONE: begin
                serial_int_req = 1'b1;
                state_nx       = SER_IDLE;
            end
            default: state_nx = SER_IDLE;
        endcase
    end

    // Registers and shift datapath; SB is write-protected while a transfer is in flight
    always_ff @(posedge core_clk) begin
        if (reset) begin
            sb      <= 8'h00;
            sc7     <= 1'b0;
            sc0     <= 1'b0;
            bit_cnt <= 3'd0;
            phase   <= '0;
            sout_r  <= 1'b1;
        end else begin
            case (state)
                SER_IDLE: begin
                    if (sb_wr) sb <= data_in;
                    if (sc_wr) begin
                        sc0 <= data_in[0];
                        if (data_in[7]) begin
                            sc7     <= 1'b1;
                            bit_cnt <= 3'd0;
                            phase   <= '0;
                            sout_r  <= sb[7];
                        end
                    end
                end
                SER_XFER_INT: begin
                    if (sc_abort) begin
                        sc7    <= 1'b0;
                        sc0    <= data_in[0];
                        sout_r <= 1'b1;
                    end else begin
                        phase <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
                        if (phase == '0)      sout_r  <= sb[7];
                        if (phase == PH_HALF) sb      <= {sb[6:0], sin};
                        if (phase == PH_LAST) bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                SER_XFER_EXT: begin
                    if (sc_abort) begin
                        sc7    <= 1'b0;
                        sc0    <= data_in[0];
                        sout_r <= 1'b1;
                    end else if (ext_rise) begin
                        sb      <= {sb[6:0], sin};
                        bit_cnt <= bit_cnt + 3'd1;
                    end else if (ext_fall) begin
                        sout_r <= sb[7];
                    end
                end
                SER_DONE: begin
                    sc7    <= 1'b0;
                    sout_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
